// File: rtl/i2c_txn_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_txn_arbiter
//  Purpose  : Shares one single-byte I2C master among NUM_REQ requesters.
//             Picks a winner among pending requests, latches the winner's
//             command for the whole transaction, launches the master with a
//             one-cycle start pulse, and returns read data plus a one-cycle
//             completion pulse to the winner.
//  Options  : ARB_ROUND_ROBIN_EN - defined: round-robin arbitration with a
//             rotating pointer; undefined: fixed priority, lowest index wins.
//  Ports    : clk_400, rst_n (async, active-low)
//             req / req_rw / req_addr / req_wdata  - packed requester fields
//             gnt / resp_valid / resp_rdata        - owner grant and response
//             m_start_txn / m_rw / m_sub_addr / m_data_in - master command
//             m_busy / m_done / m_data_ready / m_data_out - master status
//             arb_busy                             - high outside IDLE
//  Revision : 1.0 - initial release
// ============================================================================
module i2c_txn_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                   clk_400,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ-1:0]     req_rw,
    input  logic [7*NUM_REQ-1:0]   req_addr,
    input  logic [8*NUM_REQ-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [NUM_REQ-1:0]     resp_valid,
    output logic [7:0]             resp_rdata,
    output logic                   m_start_txn,
    output logic                   m_rw,
    output logic [6:0]             m_sub_addr,
    output logic [7:0]             m_data_in,
    input  logic                   m_busy,
    input  logic                   m_done,
    input  logic                   m_data_ready,
    input  logic [7:0]             m_data_out,
    output logic                   arb_busy
);

    localparam logic [7:0] c_RDATA_CLEAR = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_RESPOND   = 3'd4,
        ST_DRAIN     = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_done_prev;

    logic [IDX_W-1:0]     w_win_idx;
    logic [NUM_REQ-1:0]   w_win_onehot;
    logic                 w_sel_rw;
    logic [6:0]           w_sel_addr;
    logic [7:0]           w_sel_wdata;

    logic [NUM_REQ-1:0]   w_gnt_nxt;
    logic [NUM_REQ-1:0]   w_resp_valid_nxt;
    logic [7:0]           w_rdata_nxt;
    logic                 w_start_nxt;
    logic                 w_rw_nxt;
    logic [6:0]           w_addr_nxt;
    logic [7:0]           w_wdata_nxt;

    // ------------------------------------------------------------------
    // Winner selection
    // ------------------------------------------------------------------
`ifdef ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0]     r_rr_ptr;
    logic [IDX_W:0]       w_sum;
    logic                 w_found;

    // Search starts at the pointer and wraps; ptr < NUM_REQ and
    // offset < NUM_REQ, so one conditional subtract gives the modulo.
    always_comb begin
        w_win_idx = '0;
        w_found   = 1'b0;
        w_sum     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_sum = {1'b0, r_rr_ptr} + (IDX_W+1)'(i);
            if (w_sum >= (IDX_W+1)'(NUM_REQ)) begin
                w_sum = w_sum - (IDX_W+1)'(NUM_REQ);
            end
            if (!w_found && req[w_sum[IDX_W-1:0]]) begin
                w_found   = 1'b1;
                w_win_idx = w_sum[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge clk_400 or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if (r_state == ST_IDLE && |req) begin
            if (w_win_idx == IDX_W'(NUM_REQ-1)) begin
                r_rr_ptr <= '0;
            end else begin
                r_rr_ptr <= w_win_idx + IDX_W'(1);
            end
        end
    end
`else
    // Descending scan so the lowest set index is the last to overwrite.
    always_comb begin
        w_win_idx = '0;
        for (int i = NUM_REQ-1; i >= 0; i--) begin
            if (req[i]) begin
                w_win_idx = IDX_W'(i);
            end
        end
    end
`endif

    // Field mux for the selected requester
    always_comb begin
        w_win_onehot = '0;
        w_sel_rw     = 1'b0;
        w_sel_addr   = '0;
        w_sel_wdata  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win_idx == IDX_W'(i)) begin
                w_win_onehot[i] = 1'b1;
                w_sel_rw        = req_rw[i];
                w_sel_addr      = req_addr[7*i +: 7];
                w_sel_wdata     = req_wdata[8*i +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_gnt_nxt        = gnt;
        w_resp_valid_nxt = '0;
        w_rdata_nxt      = resp_rdata;
        w_start_nxt      = 1'b0;
        w_rw_nxt         = m_rw;
        w_addr_nxt       = m_sub_addr;
        w_wdata_nxt      = m_data_in;

        case (r_state)
            ST_IDLE: begin
                if (|req) begin
                    w_state_nxt = ST_ISSUE;
                    w_gnt_nxt   = w_win_onehot;
                    w_rw_nxt    = w_sel_rw;
                    w_addr_nxt  = w_sel_addr;
                    w_wdata_nxt = w_sel_wdata;
                    w_rdata_nxt = c_RDATA_CLEAR;
                end
            end
            ST_ISSUE: begin
                // Registered, so the pulse appears one cycle after the grant.
                w_start_nxt = 1'b1;
                w_state_nxt = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (m_busy) begin
                    w_state_nxt = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                // Read data is only meaningful for a read; a stray strobe
                // during a write must leave the cleared byte untouched.
                if (m_data_ready && m_rw) begin
                    w_rdata_nxt = m_data_out;
                end
                // Edge-detect done so a level left over from STOP can
                // never complete a transaction twice.
                if (m_done && !r_done_prev) begin
                    w_state_nxt = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                w_resp_valid_nxt = gnt;
                w_gnt_nxt        = '0;
                w_state_nxt      = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Hold off the next start until the master is fully idle.
                if (!m_busy && !m_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
                w_rdata_nxt = '0;
                w_rw_nxt    = 1'b0;
                w_addr_nxt  = '0;
                w_wdata_nxt = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_400 or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_done_prev <= 1'b0;
            gnt         <= '0;
            resp_valid  <= '0;
            resp_rdata  <= '0;
            m_start_txn <= 1'b0;
            m_rw        <= 1'b0;
            m_sub_addr  <= '0;
            m_data_in   <= '0;
            arb_busy    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_done_prev <= m_done;
            gnt         <= w_gnt_nxt;
            resp_valid  <= w_resp_valid_nxt;
            resp_rdata  <= w_rdata_nxt;
            m_start_txn <= w_start_nxt;
            m_rw        <= w_rw_nxt;
            m_sub_addr  <= w_addr_nxt;
            m_data_in   <= w_wdata_nxt;
            arb_busy    <= (w_state_nxt != ST_IDLE);
        end
    end

endmodule
`default_nettype wire

// File: doc/i2c_txn_arbiter.md
Name: i2c_txn_arbiter

Overview:
- Shares one single-byte I2C master (7-bit sub address, rw, one data byte) among NUM_REQ requesters.
- Arbitrates pending requests and latches the winner's command into registers held stable for the whole transaction.
- Launches the master with a one-cycle start pulse, tracks busy/done/data_ready, and returns read data plus a completion pulse to the winner.
- Sits between system-side register clients and the I2C master, in the clk_400 domain.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- IDX_W, $clog2(NUM_REQ): width of the grant index.

Ports:
- clk_400  in  1  400 kHz system clock, shared with the I2C master.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester request; held until that requester's resp_valid.
- req_rw  in  NUM_REQ  per-requester direction: 0 = write, 1 = read.
- req_addr  in  7*NUM_REQ  packed 7-bit sub addresses; requester i uses [7i+6:7i].
- req_wdata  in  8*NUM_REQ  packed write bytes; requester i uses [8i+7:8i].
- gnt  out  NUM_REQ  one-hot; the requester currently owning the master.
- resp_valid  out  NUM_REQ  one-cycle completion pulse to the owner.
- resp_rdata  out  8  read byte; 0x00 after a write.
- m_start_txn  out  1  start pulse to the master.
- m_rw  out  1  registered rw to the master.
- m_sub_addr  out  7  registered sub address to the master.
- m_data_in  out  8  registered write byte to the master.
- m_busy  in  1  master busy.
- m_done  in  1  master done; high while the master is in STOP.
- m_data_ready  in  1  master one-cycle read-data-valid pulse.
- m_data_out  in  8  master read byte.
- arb_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: every output 0. FSM = IDLE. Round-robin pointer = 0.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESPOND, DRAIN.
- IDLE: if any req bit is set, select a winner k and move to ISSUE on the next edge. In the same edge:
  - set gnt[k];
  - latch m_rw, m_sub_addr and m_data_in from requester k's fields;
  - set resp_rdata to 0x00.
- ISSUE: drive m_start_txn = 1 for exactly one cycle, then go to WAIT_BUSY.
- WAIT_BUSY: on m_busy = 1, go to WAIT_DONE.
- WAIT_DONE: on m_data_ready, capture m_data_out into resp_rdata. On m_done rising edge (m_done high, previous sample low), go to RESPOND.
- RESPOND: pulse resp_valid[k] for one cycle, clear gnt, go to DRAIN.
- DRAIN: once m_busy = 0 and m_done = 0, return to IDLE. This guarantees the master is back in IDLE before the next start.
- Stability: m_rw, m_sub_addr and m_data_in change only on a grant in IDLE. The master samples rw late in the transaction, so these must not move mid-transaction.
- Latency: grant to m_start_txn is 1 cycle. req assertion in IDLE to gnt is 1 cycle.
- Back-to-back: at least 1 idle cycle between RESPOND and the next ISSUE (DRAIN plus IDLE).
- Requester drops req mid-transaction: the transaction completes and resp_valid still pulses.
- Request-side field changes while granted: ignored.
- Simultaneous requests: exactly one grant; the others wait.
- A requester re-asserting req the cycle after its resp_valid is treated as a new request.
- m_data_ready during a write: ignored, resp_rdata stays 0x00.
- Reset mid-operation: immediate return to reset values; no resp_valid is issued. The master is reset by the same rst_n.
- Default/illegal FSM state: go to IDLE with all outputs cleared.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration. The search starts at pointer p and wraps modulo NUM_REQ. After each grant to k, p = (k+1) mod NUM_REQ.
- Undefined: fixed priority; the lowest set index wins; no pointer register.

Test Plan:
- Single write: req[1]=1, rw=0, addr=0x3C, wdata=0xA5, master model completes → gnt=0010 after 1 cycle, m_start_txn high for exactly 1 cycle, m_sub_addr=0x3C and m_data_in=0xA5 stable through done, resp_valid[1] pulses once, resp_rdata=0x00.
- Single read: req[2]=1, rw=1, addr=0x50, model returns 0x5A with data_ready before done → resp_rdata=0x5A when resp_valid[2] pulses.
- Contention: req=1111 held continuously.
  - Fixed priority: grants 0,0,0…
  - With ARB_ROUND_ROBIN_EN: grants 0,1,2,3,0.
  - In both modes: exactly one gnt bit high, and no m_start_txn while m_busy or m_done is high.
- Request withdrawn: req[3] deasserted while in WAIT_DONE → transaction still completes and resp_valid[3] pulses.
- Reset mid-transaction: rst_n low during WAIT_DONE → all outputs 0 asynchronously, no resp_valid; after release a fresh req[0] is served normally.
- Stale done: m_done held high for 3 cycles in STOP → one resp_valid only; the next ISSUE waits until m_done=0.
